// File: rtl/rv32i_types.sv
// Shared types for the memory-port arbiter: FSM states and grant sides.
package rv32i_types;

  typedef enum logic [2:0] {
    IDLE,
    SERVE_I,
    SERVE_D,
    RESP_I,
    RESP_D
  } arb_state_t;

  typedef enum logic {
    GRANT_I,
    GRANT_D
  } arb_grant_t;

endpackage

// File: rtl/mem_port_arbiter.sv
// Two-client arbiter for the single line-granular physical-memory port.
// I-cache (read only) and D-cache (read/write) share it round-robin; the
// winning request is registered, held until memory answers, and followed by
// a one-cycle response and a turnaround cycle back through IDLE.
module mem_port_arbiter
  import rv32i_types::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int LINE_WIDTH = 256
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_read_i,
  input  logic [ADDR_WIDTH-1:0] i_addr_i,
  output logic [LINE_WIDTH-1:0] i_rdata_o,
  output logic                  i_resp_o,
  input  logic                  d_read_i,
  input  logic                  d_write_i,
  input  logic [ADDR_WIDTH-1:0] d_addr_i,
  input  logic [LINE_WIDTH-1:0] d_wdata_i,
  output logic [LINE_WIDTH-1:0] d_rdata_o,
  output logic                  d_resp_o,
  output logic                  pmem_read_o,
  output logic                  pmem_write_o,
  output logic [ADDR_WIDTH-1:0] pmem_addr_o,
  output logic [LINE_WIDTH-1:0] pmem_wdata_o,
  input  logic [LINE_WIDTH-1:0] pmem_rdata_i,
  input  logic                  pmem_resp_i,
  output logic                  busy_o
);

  arb_state_t state_q, state_d;
  arb_grant_t last_grant_q, last_grant_d;

  logic                  pmem_read_q, pmem_write_q;
  logic [ADDR_WIDTH-1:0] pmem_addr_q;
  logic [LINE_WIDTH-1:0] pmem_wdata_q;
  logic [LINE_WIDTH-1:0] i_rdata_q, d_rdata_q;

  logic       d_req, any_req;
  arb_grant_t pick;

  // Round-robin pick: a lone requester always wins; on a tie the side that
  // did not win last time goes first.
  function automatic arb_grant_t rr_pick(input logic ireq, input logic dreq,
                                         input arb_grant_t last);
    arb_grant_t g;
    g = GRANT_I;
    if (ireq && dreq) g = (last == GRANT_D) ? GRANT_I : GRANT_D;
    else if (dreq)    g = GRANT_D;
    return g;
  endfunction

  assign d_req   = d_read_i | d_write_i;
  assign any_req = i_read_i | d_req;
  assign pick    = rr_pick(i_read_i, d_req, last_grant_q);

  // State and round-robin history registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_grant_q <= GRANT_D;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
    end
  end

  // Next state: grant from IDLE, wait for memory, always pass through RESP.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    case (state_q)
      IDLE: begin
        if (any_req) begin
          state_d      = (pick == GRANT_I) ? SERVE_I : SERVE_D;
          last_grant_d = pick;
        end
      end
      SERVE_I: if (pmem_resp_i) state_d = RESP_I;
      SERVE_D: if (pmem_resp_i) state_d = RESP_D;
      RESP_I:  state_d = IDLE;
      RESP_D:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State-decoded outputs; driven only by registers, so no input-to-output path.
  always_comb begin
    i_resp_o = (state_q == RESP_I);
    d_resp_o = (state_q == RESP_D);
    busy_o   = (state_q != IDLE);
  end

  // Memory request and returned-line registers. Requests are captured only in
  // IDLE, so requester changes during SERVE/RESP never reach the port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pmem_read_q  <= 1'b0;
      pmem_write_q <= 1'b0;
      pmem_addr_q  <= '0;
      pmem_wdata_q <= '0;
      i_rdata_q    <= '0;
      d_rdata_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (any_req) begin
            if (pick == GRANT_I) begin
              pmem_addr_q  <= i_addr_i;
              pmem_read_q  <= 1'b1;
              pmem_write_q <= 1'b0;
            end else begin
              pmem_addr_q  <= d_addr_i;
              pmem_wdata_q <= d_wdata_i;
              // Write-back wins if the D-cache raises both strobes.
              pmem_write_q <= d_write_i;
              pmem_read_q  <= ~d_write_i;
            end
          end
        end
        SERVE_I, SERVE_D: begin
          if (pmem_resp_i) begin
            pmem_read_q  <= 1'b0;
            pmem_write_q <= 1'b0;
            if (pmem_read_q) begin
              if (state_q == SERVE_I) i_rdata_q <= pmem_rdata_i;
              else                    d_rdata_q <= pmem_rdata_i;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign pmem_read_o  = pmem_read_q;
  assign pmem_write_o = pmem_write_q;
  assign pmem_addr_o  = pmem_addr_q;
  assign pmem_wdata_o = pmem_wdata_q;
  assign i_rdata_o    = i_rdata_q;
  assign d_rdata_o    = d_rdata_q;

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single line-granular physical-memory port between the instruction-fetch cache (read-only) and the MEM-stage data cache (read/write).
- Sits between both L1 caches and the cacheline adaptor.
- Registers the winning request, holds it until memory responds, returns the line and a one-cycle response to the winner, then inserts one turnaround cycle.
- Round-robin on simultaneous requests, so neither pipeline side starves.

Parameters:
ADDR_WIDTH, 32, byte address width of all ports
LINE_WIDTH, 256, cacheline data width

Ports:
clk  in  1  system clock; all state on rising edge
rst_n  in  1  asynchronous, active-low reset
i_read_i  in  1  I-cache line read request; held until i_resp_o
i_addr_i  in  ADDR_WIDTH  I-cache line address
i_rdata_o  out  LINE_WIDTH  line returned to I-cache
i_resp_o  out  1  one-cycle completion pulse to I-cache
d_read_i  in  1  D-cache line read request; held until d_resp_o
d_write_i  in  1  D-cache line write-back request; held until d_resp_o
d_addr_i  in  ADDR_WIDTH  D-cache line address
d_wdata_i  in  LINE_WIDTH  D-cache write-back line
d_rdata_o  out  LINE_WIDTH  line returned to D-cache
d_resp_o  out  1  one-cycle completion pulse to D-cache
pmem_read_o  out  1  registered read request to memory
pmem_write_o  out  1  registered write request to memory
pmem_addr_o  out  ADDR_WIDTH  registered memory address
pmem_wdata_o  out  LINE_WIDTH  registered write line
pmem_rdata_i  in  LINE_WIDTH  memory read line, valid with pmem_resp_i
pmem_resp_i  in  1  memory completion pulse
busy_o  out  1  high in any state other than IDLE

Behaviour:
- States: IDLE, SERVE_I, SERVE_D, RESP_I, RESP_D.
- Reset values:
  - All outputs 0; state IDLE; last_grant = D.
- IDLE:
  - Only I requesting: latch i_addr_i into pmem_addr_o, set pmem_read_o, go to SERVE_I.
  - Only D requesting: latch d_addr_i and d_wdata_i, set pmem_write_o if d_write_i else pmem_read_o, go to SERVE_D.
  - Both requesting: grant the side opposite last_grant.
  - Every grant updates last_grant to the granted side.
- Request latency: request visible in IDLE cycle N gives pmem_read_o/pmem_write_o high from cycle N+1.
- SERVE_x:
  - pmem_* stay constant; requester input changes are ignored.
  - On pmem_resp_i:
    - Clear pmem_read_o/pmem_write_o.
    - Register pmem_rdata_i into x_rdata_o (reads only; writes leave x_rdata_o unchanged).
    - Go to RESP_x.
- RESP_x:
  - x_resp_o = 1 for exactly this cycle.
  - Next state IDLE unconditionally.
  - This is the turnaround cycle: the requester drops its request on the edge ending RESP_x, so IDLE never sees a stale request.
- x_rdata_o holds its value until the next read completion for that side.
- d_read_i and d_write_i both high: write has precedence (pmem_write_o).
- pmem_resp_i in IDLE or RESP_x: ignored, no state or output change.
- Back-to-back:
  - The minimum gap between completion of one transaction and assertion of the next pmem request is 2 cycles (RESP_x, IDLE).
  - A request pending during SERVE/RESP is granted in the following IDLE cycle.
- Reset mid-transaction:
  - All pmem_* and resp outputs clear immediately (async).
  - State returns to IDLE; last_grant returns to D.
  - A late pmem_resp_i is then ignored.
- Exactly one of pmem_read_o/pmem_write_o is high in SERVE states; both are 0 elsewhere.
- No combinational path from any input to any output.

Decomposition:
- Package rv32i_types: add enum arb_state_t {IDLE, SERVE_I, SERVE_D, RESP_I, RESP_D} and enum arb_grant_t {GRANT_I, GRANT_D}.
- Single module; no sub-module needed.
- A grant-select function (round-robin pick from two request bits plus last_grant) lives locally.

Test Plan:
- I read only: i_read_i=1, i_addr_i=0x0000_0060, memory responds 4 cycles after request with 0xAA..AA.
  - pmem_read_o=1, pmem_addr_o=0x60 from next cycle.
  - i_resp_o pulses once, with i_rdata_o=0xAA..AA.
  - d_resp_o stays 0.
- D write-back: d_write_i=1, d_addr_i=0x8000_1000, d_wdata_i=0x1234..; then d_read_i=1 with d_addr_i=0x8000_2000.
  - pmem_write_o with that address and data, d_resp_o pulses.
  - The read is issued after exactly 2 idle cycles (RESP_D, IDLE).
- Simultaneous requests after reset: i_read_i and d_read_i both high.
  - I served first, then D.
  - Repeat with both held: order alternates D, I.
  - No side waits more than one foreign transaction.
- Protocol stress:
  - d_read_i and d_write_i both high: write issued.
  - pmem_resp_i pulsed in IDLE: no output change.
  - i_addr_i changed mid-SERVE_I: pmem_addr_o unchanged.
- Reset mid-transaction: assert rst_n=0 during SERVE_D with pmem_write_o=1.
  - All outputs 0 asynchronously.
  - After release, pmem_resp_i produces no d_resp_o.
  - Next simultaneous request grants I.
